// File: rtl/wb_master_arbiter_pkg.sv
// Shared definitions for the Wishbone master arbiter: FSM state encodings and
// the round-robin pointer width helper.
package wb_master_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN  = 2'd1;
  localparam logic [1:0] ST_TOUT = 2'd2;

  localparam int TCNT_W = 16;

  // A single master still needs a 1-bit pointer so port widths never collapse to zero.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: rotate requests so the pointer sits at bit 0,
// take the lowest set bit, rotate the one-hot result back.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);

  logic [N-1:0] w_rot;
  logic [N-1:0] w_rot_gnt;

  assign w_rot     = N'({i_req, i_req} >> i_ptr);
  assign w_rot_gnt = w_rot & (~w_rot + N'(1));
  // Upper half of the doubled, left-shifted vector is the un-rotated grant.
  assign o_gnt     = N'(({w_rot_gnt, w_rot_gnt} << i_ptr) >> N);

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave bus between N_MASTERS masters,
// with a stall watchdog that forces err when the slave never answers.
module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [N_MASTERS-1:0]        i_m_cyc,
  input  logic [N_MASTERS-1:0]        i_m_stb,
  input  logic [N_MASTERS-1:0]        i_m_we,
  input  logic [N_MASTERS*ADDR_W-1:0] i_m_adr,
  input  logic [N_MASTERS*DATA_W-1:0] i_m_dat,
  output logic [DATA_W-1:0]           o_m_dat,
  output logic [N_MASTERS-1:0]        o_m_ack,
  output logic [N_MASTERS-1:0]        o_m_err,
  output logic                        o_s_cyc,
  output logic                        o_s_stb,
  output logic                        o_s_we,
  output logic [ADDR_W-1:0]           o_s_adr,
  output logic [DATA_W-1:0]           o_s_dat,
  input  logic [DATA_W-1:0]           i_s_dat,
  input  logic                        i_s_ack,
  input  logic                        i_s_err,
  output logic [N_MASTERS-1:0]        o_grant,
  output logic [TCNT_W-1:0]           o_timeout_cnt
);

  localparam int PW   = ptr_width(N_MASTERS);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [1:0]           r_state;
  logic [N_MASTERS-1:0] r_grant;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        r_idx;
  logic [WD_W-1:0]      r_wd;
  logic [TCNT_W-1:0]    r_timeout_cnt;

  logic [N_MASTERS-1:0] w_req;
  logic [N_MASTERS-1:0] w_rr_gnt;
  logic [PW-1:0]        w_rr_idx;
  logic [PW-1:0]        w_ptr_next;
  logic                 w_own;
  logic                 w_own_cyc;
  logic                 w_own_stb;
  logic                 w_own_we;
  logic [ADDR_W-1:0]    w_own_adr;
  logic [DATA_W-1:0]    w_own_dat;
  logic                 w_stall;
  logic                 w_wd_hit;

  assign w_req = i_m_cyc & i_m_stb;

  rr_arbiter #(
    .N  (N_MASTERS),
    .PW (PW)
  ) u_rr (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_rr_gnt)
  );

  // r_grant is one-hot or zero, so OR-ing the selected lanes is a clean mux.
  always_comb begin
    w_own_adr = '0;
    w_own_dat = '0;
    w_rr_idx  = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (r_grant[k]) begin
        w_own_adr = w_own_adr | i_m_adr[k*ADDR_W +: ADDR_W];
        w_own_dat = w_own_dat | i_m_dat[k*DATA_W +: DATA_W];
      end
      if (w_rr_gnt[k]) begin
        w_rr_idx = PW'(k);
      end
    end
  end

  assign w_own      = (r_state == ST_OWN);
  assign w_own_cyc  = |(r_grant & i_m_cyc);
  assign w_own_stb  = |(r_grant & i_m_stb);
  assign w_own_we   = |(r_grant & i_m_we);
  assign w_ptr_next = (r_idx == PW'(N_MASTERS - 1)) ? '0 : r_idx + PW'(1);

  assign w_stall  = o_s_stb & ~i_s_ack & ~i_s_err;
  assign w_wd_hit = w_stall && (r_wd == WD_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_ptr         <= '0;
      r_idx         <= '0;
      r_wd          <= '0;
      r_timeout_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wd <= '0;
          if (|w_req) begin
            r_state <= ST_OWN;
            r_grant <= w_rr_gnt;
            r_idx   <= w_rr_idx;
          end
        end
        ST_OWN: begin
          if (!w_own_cyc) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= w_ptr_next;
            r_wd    <= '0;
          end else if (w_wd_hit) begin
            r_state <= ST_TOUT;
            r_wd    <= '0;
            if (r_timeout_cnt != '1) begin
              r_timeout_cnt <= r_timeout_cnt + TCNT_W'(1);
            end
          end else if (w_stall) begin
            r_wd <= r_wd + WD_W'(1);
          end else begin
            r_wd <= '0;
          end
        end
        ST_TOUT: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_ptr   <= w_ptr_next;
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  // Late ack/err outside OWN is dropped; TOUT supplies the forced err itself.
  assign o_s_cyc       = w_own & w_own_cyc;
  assign o_s_stb       = w_own & w_own_cyc & w_own_stb;
  assign o_s_we        = w_own & w_own_we;
  assign o_s_adr       = w_own ? w_own_adr : '0;
  assign o_s_dat       = w_own ? w_own_dat : '0;
  assign o_m_dat       = i_s_dat;
  assign o_m_ack       = w_own ? (r_grant & {N_MASTERS{i_s_ack}}) : '0;
  assign o_m_err       = ((r_state == ST_TOUT) || (w_own && i_s_err)) ? r_grant : '0;
  assign o_grant       = r_grant;
  assign o_timeout_cnt = r_timeout_cnt;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: per-cycle vector table for grant/routing behaviour,
// then hand-written sequences for watchdog timeout, ack-at-boundary and mid-cycle reset.
module tb_wb_master_arbiter;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [DW-1:0]   o_m_dat;
  logic [N-1:0]    o_m_ack, o_m_err, o_grant;
  logic            o_s_cyc, o_s_stb, o_s_we;
  logic [AW-1:0]   o_s_adr;
  logic [DW-1:0]   o_s_dat;
  logic [DW-1:0]   s_dat;
  logic            s_ack, s_err;
  logic [15:0]     o_tcnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_master_arbiter #(
    .N_MASTERS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TIMEOUT   (TO)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_m_cyc       (m_cyc),
    .i_m_stb       (m_stb),
    .i_m_we        (m_we),
    .i_m_adr       (m_adr),
    .i_m_dat       (m_dat),
    .o_m_dat       (o_m_dat),
    .o_m_ack       (o_m_ack),
    .o_m_err       (o_m_err),
    .o_s_cyc       (o_s_cyc),
    .o_s_stb       (o_s_stb),
    .o_s_we        (o_s_we),
    .o_s_adr       (o_s_adr),
    .o_s_dat       (o_s_dat),
    .i_s_dat       (s_dat),
    .i_s_ack       (s_ack),
    .i_s_err       (s_err),
    .o_grant       (o_grant),
    .o_timeout_cnt (o_tcnt)
  );

  typedef struct {
    logic        rst_n;
    logic [1:0]  cyc, stb, we;
    logic [15:0] adr0, adr1;
    logic [7:0]  dat0, dat1;
    logic        ack, err;
    logic [7:0]  sdat;
    logic [1:0]  e_grant;
    logic        e_scyc, e_sstb, e_swe;
    logic [15:0] e_sadr;
    logic [7:0]  e_sdat;
    logic [1:0]  e_ack, e_err;
  } vec_t;

  vec_t vecs[$];
  logic [15:0] cur_adr0, cur_adr1;
  logic [7:0]  cur_dat0, cur_dat1, cur_sdat;

  function automatic vec_t mk(input logic r, input logic [1:0] cyc, input logic [1:0] stb,
                              input logic [1:0] we, input logic ack, input logic err,
                              input logic [1:0] eg, input logic ecyc, input logic estb,
                              input logic ewe, input logic [15:0] eadr, input logic [7:0] edat,
                              input logic [1:0] eack, input logic [1:0] eerr);
    vec_t v;
    v.rst_n = r;    v.cyc = cyc;  v.stb = stb;  v.we = we;
    v.adr0 = cur_adr0; v.adr1 = cur_adr1; v.dat0 = cur_dat0; v.dat1 = cur_dat1;
    v.ack = ack;    v.err = err;  v.sdat = cur_sdat;
    v.e_grant = eg; v.e_scyc = ecyc; v.e_sstb = estb; v.e_swe = ewe;
    v.e_sadr = eadr; v.e_sdat = edat; v.e_ack = eack; v.e_err = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input int i, input vec_t v);
    @(negedge clk);
    rst_n = v.rst_n; m_cyc = v.cyc; m_stb = v.stb; m_we = v.we;
    m_adr = {v.adr1, v.adr0}; m_dat = {v.dat1, v.dat0};
    s_ack = v.ack; s_err = v.err; s_dat = v.sdat;
    #1;
    chk($sformatf("v%0d.grant", i), o_grant, v.e_grant);
    chk($sformatf("v%0d.s_cyc", i), o_s_cyc, v.e_scyc);
    chk($sformatf("v%0d.s_stb", i), o_s_stb, v.e_sstb);
    chk($sformatf("v%0d.s_we", i),  o_s_we,  v.e_swe);
    chk($sformatf("v%0d.s_adr", i), o_s_adr, v.e_sadr);
    chk($sformatf("v%0d.s_dat", i), o_s_dat, v.e_sdat);
    chk($sformatf("v%0d.m_ack", i), o_m_ack, v.e_ack);
    chk($sformatf("v%0d.m_err", i), o_m_err, v.e_err);
    chk($sformatf("v%0d.m_dat", i), o_m_dat, v.sdat);
    chk($sformatf("v%0d.tcnt", i),  o_tcnt,  16'd0);
    $display("vec %0d: cyc=%b stb=%b ack=%b err=%b -> grant=%b s_stb=%b m_ack=%b m_err=%b",
             i, v.cyc, v.stb, v.ack, v.err, o_grant, o_s_stb, o_m_ack, o_m_err);
  endtask

  task automatic drive(input logic [1:0] cyc, input logic [1:0] stb, input logic ack, input logic err);
    @(negedge clk);
    m_cyc = cyc; m_stb = stb; s_ack = ack; s_err = err;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0;
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0;
    repeat (2) @(posedge clk);

    // Single read by M0, slave acks two cycles after stb.
    cur_adr0 = 16'h0010; cur_adr1 = 16'h0000; cur_dat0 = 8'h00; cur_dat1 = 8'h00; cur_sdat = 8'hA5;
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 16'h0000, 8'h00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 0, 2'b00, 0, 0, 0, 16'h0000, 8'h00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 0, 2'b01, 1, 1, 0, 16'h0010, 8'h00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 0, 2'b01, 1, 1, 0, 16'h0010, 8'h00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 1, 0, 2'b01, 1, 1, 0, 16'h0010, 8'h00, 2'b01, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b01, 0, 0, 0, 16'h0010, 8'h00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 0, 0, 0, 16'h0000, 8'h00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 16'h0000, 8'h00, 2'b00, 2'b00));
    // Contention after reset: M0 first, then M1; repeated contention goes to M1 first.
    cur_adr0 = 16'h0100; cur_adr1 = 16'h0200; cur_dat0 = 8'h11; cur_dat1 = 8'h22; cur_sdat = 8'h5A;
    vecs.push_back(mk(1, 2'b11, 2'b11, 2'b10, 0, 0, 2'b00, 0, 0, 0, 16'h0000, 8'h00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b11, 2'b11, 2'b10, 0, 0, 2'b01, 1, 1, 0, 16'h0100, 8'h11, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b11, 2'b11, 2'b10, 1, 0, 2'b01, 1, 1, 0, 16'h0100, 8'h11, 2'b01, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b10, 0, 0, 2'b01, 0, 0, 0, 16'h0100, 8'h11, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b10, 0, 0, 2'b00, 0, 0, 0, 16'h0000, 8'h00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b11, 2'b11, 2'b10, 0, 0, 2'b00, 0, 0, 0, 16'h0000, 8'h00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b11, 2'b11, 2'b10, 0, 0, 2'b10, 1, 1, 1, 16'h0200, 8'h22, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b11, 2'b11, 2'b10, 1, 0, 2'b10, 1, 1, 1, 16'h0200, 8'h22, 2'b10, 2'b00));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b10, 0, 0, 2'b10, 0, 0, 1, 16'h0200, 8'h22, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b10, 0, 0, 2'b00, 0, 0, 0, 16'h0000, 8'h00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b10, 0, 0, 2'b01, 1, 1, 0, 16'h0100, 8'h11, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b10, 1, 0, 2'b01, 1, 1, 0, 16'h0100, 8'h11, 2'b01, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b10, 0, 0, 2'b01, 0, 0, 0, 16'h0100, 8'h11, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 16'h0000, 8'h00, 2'b00, 2'b00));
    // Burst: M1 holds cyc for four acked strobes while M0 waits.
    cur_adr1 = 16'h0300; cur_dat1 = 8'h33; cur_sdat = 8'h3C;
    vecs.push_back(mk(1, 2'b11, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 0, 16'h0000, 8'h00, 2'b00, 2'b00));
    for (int b = 0; b < 4; b++)
      vecs.push_back(mk(1, 2'b11, 2'b11, 2'b00, 1, 0, 2'b10, 1, 1, 0, 16'h0300, 8'h33, 2'b10, 2'b00));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 0, 2'b10, 0, 0, 0, 16'h0300, 8'h33, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 0, 2'b00, 0, 0, 0, 16'h0000, 8'h00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 0, 2'b01, 1, 1, 0, 16'h0100, 8'h11, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b01, 0, 0, 0, 16'h0100, 8'h11, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 16'h0000, 8'h00, 2'b00, 2'b00));
    // Slave err, ack+err together, late err in IDLE.
    cur_adr0 = 16'h0040; cur_dat0 = 8'h44; cur_sdat = 8'hE1;
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b01, 0, 0, 2'b00, 0, 0, 0, 16'h0000, 8'h00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b01, 0, 1, 2'b01, 1, 1, 1, 16'h0040, 8'h44, 2'b00, 2'b01));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b01, 1, 1, 2'b01, 1, 1, 1, 16'h0040, 8'h44, 2'b01, 2'b01));
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b01, 0, 0, 2'b01, 0, 0, 1, 16'h0040, 8'h44, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 1, 2'b00, 0, 0, 0, 16'h0000, 8'h00, 2'b00, 2'b00));

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Watchdog: eight stalled cycles, forced err on the ninth.
    m_adr = {16'h0000, 16'h0400}; m_we = '0; s_dat = 8'h00;
    drive(2'b01, 2'b01, 0, 0);
    chk("to.req_grant", o_grant, 2'b00);
    for (int c = 1; c <= TO; c++) begin
      drive(2'b01, 2'b01, 0, 0);
      chk($sformatf("to.c%0d.grant", c), o_grant, 2'b01);
      chk($sformatf("to.c%0d.s_stb", c), o_s_stb, 1'b1);
      chk($sformatf("to.c%0d.m_err", c), o_m_err, 2'b00);
    end
    drive(2'b01, 2'b01, 0, 0);
    chk("to.tout.m_err", o_m_err, 2'b01);
    chk("to.tout.s_stb", o_s_stb, 1'b0);
    chk("to.tout.s_cyc", o_s_cyc, 1'b0);
    chk("to.tout.grant", o_grant, 2'b01);
    drive(2'b00, 2'b00, 0, 0);
    chk("to.after.grant", o_grant, 2'b00);
    chk("to.after.tcnt", o_tcnt, 16'd1);
    chk("to.after.m_err", o_m_err, 2'b00);
    $display("timeout seq: tcnt=%0d grant=%b", o_tcnt, o_grant);

    // Ack exactly on the cycle the watchdog would fire.
    drive(2'b01, 2'b01, 0, 0);
    for (int c = 1; c < TO; c++) begin
      drive(2'b01, 2'b01, 0, 0);
      chk($sformatf("bnd.c%0d.m_err", c), o_m_err, 2'b00);
    end
    drive(2'b01, 2'b01, 1, 0);
    chk("bnd.ack.m_ack", o_m_ack, 2'b01);
    chk("bnd.ack.m_err", o_m_err, 2'b00);
    drive(2'b00, 2'b00, 0, 0);
    chk("bnd.drop.m_err", o_m_err, 2'b00);
    chk("bnd.drop.grant", o_grant, 2'b01);
    drive(2'b00, 2'b00, 0, 0);
    chk("bnd.idle.grant", o_grant, 2'b00);
    chk("bnd.idle.tcnt", o_tcnt, 16'd1);
    $display("boundary seq: tcnt=%0d grant=%b", o_tcnt, o_grant);

    // Reset while M1 owns the bus with stb high; a following ack is not routed.
    m_adr = {16'h0600, 16'h0000};
    drive(2'b10, 2'b10, 0, 0);
    drive(2'b10, 2'b10, 0, 0);
    chk("rst.own.grant", o_grant, 2'b10);
    chk("rst.own.s_stb", o_s_stb, 1'b1);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("rst.assert.s_stb", o_s_stb, 1'b1);
    @(negedge clk); rst_n = 1'b1; m_cyc = '0; m_stb = '0; s_ack = 1'b1; #1;
    chk("rst.after.grant", o_grant, 2'b00);
    chk("rst.after.s_cyc", o_s_cyc, 1'b0);
    chk("rst.after.s_stb", o_s_stb, 1'b0);
    chk("rst.after.s_adr", o_s_adr, 16'h0000);
    chk("rst.after.m_ack", o_m_ack, 2'b00);
    chk("rst.after.m_err", o_m_err, 2'b00);
    chk("rst.after.tcnt", o_tcnt, 16'd0);
    drive(2'b00, 2'b00, 0, 0);
    $display("reset seq: grant=%b m_ack=%b tcnt=%0d", o_grant, o_m_ack, o_tcnt);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
